abs_diff_approx_pipe: RTL

Parametrised, pipelined absolute-difference unit with runtime-selectable exact or approximate (LSB-truncated) result and an on-line error monitor. It generalises the fixed 2-bit combinational abs-diff cores to WIDTH-bit operands behind a valid/ready stream interface. It accumulates error statistics against the error threshold ET, so approximate configurations can be qualified in-system. It sits between an operand source stream and a result consumer in the approximate-arithmetic datapath.

---
 rtl/abs_diff_pkg.sv | 36 +++
 rtl/abs_diff_err_stats.sv | 59 +++++
 rtl/abs_diff_approx_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/abs_diff_pkg.sv
// Shared helpers for the abs-diff pipeline: magnitude, LSB truncation and
// saturating increment. Functions work on a MAX_W-bit container; callers
// zero-extend their operands in and cast the result back to their own width.
package abs_diff_pkg;

    localparam int MAX_W = 32;

    // Unsigned magnitude of a-b.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Clear the low n bits of x.
    function automatic logic [MAX_W-1:0] trunc_lsb(input logic [MAX_W-1:0] x,
                                                   input int n);
        logic [MAX_W-1:0] mask;
        mask = '1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) mask[i] = 1'b0;
        end
        return x & mask;
    endfunction

    // Increment x treated as a w-bit counter, sticking at all-ones.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] x,
                                                 input int w);
        logic [MAX_W-1:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) ones[i] = 1'b1;
        end
        return (x == ones) ? x : (x + 1'b1);
    endfunction

endpackage

// File: rtl/abs_diff_err_stats.sv
// Error statistics: delivered-sample count, threshold violations and the
// largest error seen. Counters saturate; clear beats a coincident sample.
module abs_diff_err_stats
    import abs_diff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ET    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire,
    input  logic [WIDTH-1:0] err,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [WIDTH-1:0] max_err
);

    localparam logic [WIDTH-1:0] ET_W = WIDTH'(ET);

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [WIDTH-1:0] max_err_q, max_err_d;

    // Next-state: clear first, otherwise fold in the delivered sample.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        viol_cnt_d   = viol_cnt_q;
        max_err_d    = max_err_q;
        if (clear_stats) begin
            sample_cnt_d = '0;
            viol_cnt_d   = '0;
            max_err_d    = '0;
        end else if (fire) begin
            sample_cnt_d = CNT_W'(sat_inc(MAX_W'(sample_cnt_q), CNT_W));
            if (err > ET_W) viol_cnt_d = CNT_W'(sat_inc(MAX_W'(viol_cnt_q), CNT_W));
            if (err > max_err_q) max_err_d = err;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            viol_cnt_q   <= viol_cnt_d;
            max_err_q    <= max_err_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign viol_cnt   = viol_cnt_q;
    assign max_err    = max_err_q;

endmodule

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage |a-b| with exact or LSB-truncated result and on-line error
// statistics. Stage 1 holds both signed-extended differences for exact and
// truncated operands; stage 2 picks magnitudes and the per-sample error.
// Both stages advance together whenever the output slot is free or drained.
module abs_diff_approx_pipe
    import abs_diff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2,
    parameter int ET    = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic [WIDTH-1:0] out_err,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [WIDTH-1:0] max_err
);

    localparam int STAGES = 2;

    logic              adv;
    logic [STAGES:1]   vld_pipe_q;
    logic [WIDTH-1:0]  a_t, b_t;
    logic [WIDTH:0]    s1_ab_q, s1_ba_q, s1_tab_q, s1_tba_q;
    logic              s1_approx_q;
    logic [WIDTH-1:0]  exact_mag, approx_mag, diff_d, err_d;
    logic [WIDTH-1:0]  out_diff_q, out_err_q;

    assign adv       = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[STAGES];

    assign a_t = WIDTH'(trunc_lsb(MAX_W'(in_a), TRUNC));
    assign b_t = WIDTH'(trunc_lsb(MAX_W'(in_b), TRUNC));

    // Valid shift register; a bubble in stage 1 shows up as out_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
    end

    // Stage 1: both operand orders at WIDTH+1 bits; the MSB is the borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ab_q     <= '0;
            s1_ba_q     <= '0;
            s1_tab_q    <= '0;
            s1_tba_q    <= '0;
            s1_approx_q <= 1'b0;
        end else if (adv && in_valid) begin
            s1_ab_q     <= {1'b0, in_a} - {1'b0, in_b};
            s1_ba_q     <= {1'b0, in_b} - {1'b0, in_a};
            s1_tab_q    <= {1'b0, a_t} - {1'b0, b_t};
            s1_tba_q    <= {1'b0, b_t} - {1'b0, a_t};
            s1_approx_q <= approx_en;
        end
    end

    // Stage 2 select: borrow set means the reversed difference is positive.
    always_comb begin
        exact_mag  = s1_ab_q[WIDTH]  ? s1_ba_q[WIDTH-1:0]  : s1_ab_q[WIDTH-1:0];
        approx_mag = s1_tab_q[WIDTH] ? s1_tba_q[WIDTH-1:0] : s1_tab_q[WIDTH-1:0];
        diff_d     = s1_approx_q ? approx_mag : exact_mag;
        err_d      = WIDTH'(abs_mag(MAX_W'(approx_mag), MAX_W'(exact_mag)));
    end

    // Stage 2 output registers, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_diff_q <= '0;
            out_err_q  <= '0;
        end else if (adv && vld_pipe_q[1]) begin
            out_diff_q <= diff_d;
            out_err_q  <= err_d;
        end
    end

    assign out_diff = out_diff_q;
    assign out_err  = out_err_q;

    abs_diff_err_stats #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ET    (ET)
    ) u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .fire        (out_valid && out_ready),
        .err         (out_err_q),
        .clear_stats (clear_stats),
        .sample_cnt  (sample_cnt),
        .viol_cnt    (viol_cnt),
        .max_err     (max_err)
    );

endmodule
